// File: rtl/sbox_share_ctrl_pkg.sv
// Shared types for the S-box sharing controller.
// FSM states, job owner and engine latency.
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_KEY = 1'b0,
        OWN_ST  = 1'b1
    } owner_e;

    localparam int SBOX_RUN_LAT = 7;
    localparam int ST_WORDS     = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// Bus between the sharing controller and one sbox_word engine.
// master = controller, slave = engine.
interface sbox_share_ctrl_if;

    logic        sbx_start_o;
    logic        sbx_decrypt_o;
    logic [31:0] sbx_data_o;
    logic        sbx_ready_i;
    logic [31:0] sbx_data_i;

    modport master (
        output sbx_start_o, sbx_decrypt_o, sbx_data_o,
        input  sbx_ready_i, sbx_data_i
    );

    modport slave (
        input  sbx_start_o, sbx_decrypt_o, sbx_data_o,
        output sbx_ready_i, sbx_data_i
    );

endinterface

// File: rtl/sbox_share_ctrl_arb.sv
// Two-way grant logic for key and state jobs.
// SBOX_RR_ARB_EN selects round-robin, else key has priority.
module sbox_req_arb
    import aes_sbox_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   key_req,
    input  logic   st_req,
    input  logic   upd,
    input  owner_e upd_own,
    output logic   gnt_vld,
    output owner_e gnt_own
);

    assign gnt_vld = key_req | st_req;

`ifdef SBOX_RR_ARB_EN
    owner_e last_q;

    // remember who the most recently completed job served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= OWN_ST;
        end else if (upd) begin
            last_q <= upd_own;
        end
    end

    // on a tie favour whoever was not served last
    always_comb begin
        gnt_own = OWN_KEY;
        unique case (1'b1)
            key_req && st_req:
                gnt_own = (last_q == OWN_KEY) ? OWN_ST : OWN_KEY;
            !key_req && st_req:
                gnt_own = OWN_ST;
            default:
                gnt_own = OWN_KEY;
        endcase
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, upd, upd_own};
    assign gnt_own   = (st_req && !key_req) ? OWN_ST : OWN_KEY;
`endif

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one sbox_word engine between round datapath and key expansion.
// Arbitration mode set by SBOX_RR_ARB_EN (see sbox_req_arb).
module sbox_share_ctrl
    import aes_sbox_pkg::*;
#(
    parameter int NUM_WORDS   = ST_WORDS,
    parameter int TIMEOUT_CYC = 2 * SBOX_RUN_LAT + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_req_i,
    input  logic                   st_decrypt_i,
    input  logic [32*NUM_WORDS-1:0] st_data_i,
    output logic                   st_done_o,
    output logic [32*NUM_WORDS-1:0] st_data_o,
    input  logic                   key_req_i,
    input  logic [31:0]            key_data_i,
    output logic                   key_done_o,
    output logic [31:0]            key_data_o,
    output logic                   busy_o,
    output logic                   err_o,
    sbox_share_ctrl_if.master      sbx
);

    localparam int IW = idx_w(NUM_WORDS);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int DW = 32 * NUM_WORDS;
    localparam int RW = DW - 32;

    state_e          state_q, state_n;
    owner_e          own_q, gnt_own;
    logic            gnt_vld;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   rem_q;
    logic [31:0]     sbx_data_q;
    logic            sbx_dec_q;
    logic [DW-1:0]   st_data_q;
    logic [31:0]     key_data_q;
    logic            err_q;
    logic            take, store, tmo, last_word, job_end;

    assign last_word = (own_q == OWN_KEY) || (idx_q == IW'(NUM_WORDS - 1));
    assign job_end   = (state_q == S_DONE);

    sbox_req_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_req (key_req_i),
        .st_req  (st_req_i),
        .upd     (job_end),
        .upd_own (own_q),
        .gnt_vld (gnt_vld),
        .gnt_own (gnt_own)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // next state and per-cycle strobes
    always_comb begin
        state_n = state_q;
        take    = 1'b0;
        store   = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    take    = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (sbx.sbx_ready_i) begin
                    store   = 1'b1;
                    state_n = last_word ? S_DONE : S_ISSUE;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    tmo     = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // job owner, word stream to the engine and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q      <= OWN_KEY;
            idx_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            sbx_data_q <= '0;
            sbx_dec_q  <= 1'b0;
            st_data_q  <= '0;
            key_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (take) begin
                own_q <= gnt_own;
                idx_q <= '0;
                cnt_q <= '0;
                if (gnt_own == OWN_KEY) begin
                    sbx_data_q <= key_data_i;
                    sbx_dec_q  <= 1'b0;
                end else begin
                    sbx_data_q <= st_data_i[31:0];
                    rem_q      <= st_data_i[DW-1:32];
                    sbx_dec_q  <= st_decrypt_i;
                end
            end
            if (state_q == S_ISSUE) cnt_q <= '0;
            if (state_q == S_WAIT)  cnt_q <= cnt_q + 1'b1;
            if (store) begin
                if (own_q == OWN_KEY) key_data_q <= sbx.sbx_data_i;
                else st_data_q[32*idx_q +: 32] <= sbx.sbx_data_i;
            end
            if (store && !last_word) begin
                idx_q      <= idx_q + 1'b1;
                sbx_data_q <= rem_q[31:0];
                rem_q      <= rem_q >> 32;
            end
            if (state_n == S_DONE) begin
                sbx_data_q <= '0;
                sbx_dec_q  <= 1'b0;
            end
            if (tmo) err_q <= 1'b1;
        end
    end

    assign sbx.sbx_start_o   = (state_q == S_ISSUE);
    assign sbx.sbx_decrypt_o = sbx_dec_q;
    assign sbx.sbx_data_o    = sbx_data_q;

    assign st_done_o  = job_end && (own_q == OWN_ST);
    assign key_done_o = job_end && (own_q == OWN_KEY);
    assign st_data_o  = st_data_q;
    assign key_data_o = key_data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl with a 7-cycle sbox_word stub.
// Define SBOX_RR_ARB_EN to expect round-robin tie-breaks.
module tb_sbox_share_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         st_req = 1'b0;
    logic         st_dec = 1'b0;
    logic [127:0] st_data = '0;
    logic         st_done;
    logic [127:0] st_q;
    logic         key_req = 1'b0;
    logic [31:0]  key_data = '0;
    logic         key_done;
    logic [31:0]  key_q;
    logic         busy, err;
    logic         stub_off = 1'b0;
    logic [6:0]   pipe;

    int n_chk = 0;
    int n_fail = 0;
    int starts = 0;
    int dec_cyc = 0;

    always #5 clk = ~clk;

    sbox_share_ctrl_if sbx ();

    sbox_share_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_req_i     (st_req),
        .st_decrypt_i (st_dec),
        .st_data_i    (st_data),
        .st_done_o    (st_done),
        .st_data_o    (st_q),
        .key_req_i    (key_req),
        .key_data_i   (key_data),
        .key_done_o   (key_done),
        .key_data_o   (key_q),
        .busy_o       (busy),
        .err_o        (err),
        .sbx          (sbx)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic dec);
        logic [7:0] t;
        if (!dec) begin
            t = ginv(b);
            return t ^ rotl8(t, 1) ^ rotl8(t, 2) ^ rotl8(t, 3) ^ rotl8(t, 4) ^ 8'h63;
        end
        t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic dec);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sub_byte(w[8*i +: 8], dec);
        return r;
    endfunction

    // engine stub: ready 7 cycles after start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[5:0], sbx.sbx_start_o};
    end

    assign sbx.sbx_ready_i = pipe[6] & ~stub_off;
    assign sbx.sbx_data_i  = sbx.sbx_ready_i ?
        sub_word(sbx.sbx_data_o, sbx.sbx_decrypt_o) : 32'hDEAD_BEEF;

    // count start pulses and cycles with decrypt select high
    always @(posedge clk) begin
        if (sbx.sbx_start_o)   starts  <= starts + 1;
        if (sbx.sbx_decrypt_o) dec_cyc <= dec_cyc + 1;
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_jobs(input int budget, input bit scramble,
                            output int k_key, output int k_st,
                            output int n_key, output int n_st);
        k_key = -1;
        k_st  = -1;
        n_key = 0;
        n_st  = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (scramble && k == 2) begin
                st_data  = ~st_data;
                key_data = ~key_data;
            end
            if (key_done) begin
                n_key++;
                if (k_key < 0) k_key = k;
                key_req = 1'b0;
            end
            if (st_done) begin
                n_st++;
                if (k_st < 0) k_st = k;
                st_req = 1'b0;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_st"}, st_q, 0);
        check({tag, "_key"}, key_q, 0);
        check({tag, "_start"}, sbx.sbx_start_o, 0);
        check({tag, "_sdata"}, sbx.sbx_data_o, 0);
        check({tag, "_sdec"}, sbx.sbx_decrypt_o, 0);
        check({tag, "_done"}, {key_done, st_done}, 0);
    endtask

    localparam logic [127:0] PT = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] CT = 128'h637C777BF26B6FC53001672BFED7AB76;

    initial begin
        int kk, ks, nk, ns, s0, d0;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // key job alone, inputs scrambled after grant
        key_data = 32'h0001_53FF;
        key_req  = 1'b1;
        s0 = starts;
        d0 = dec_cyc;
        run_jobs(20, 1'b1, kk, ks, nk, ns);
        check("key_lat", kk, 9);
        check("key_npulse", nk, 1);
        check("key_nost", ns, 0);
        check("key_res", key_q, 32'h637C_ED16);
        check("key_starts", starts - s0, 1);
        check("key_dec", dec_cyc - d0, 0);

        // state encrypt, inputs scrambled after grant
        st_data = PT;
        st_dec  = 1'b0;
        st_req  = 1'b1;
        s0 = starts;
        run_jobs(45, 1'b1, kk, ks, nk, ns);
        check("enc_lat", ks, 33);
        check("enc_npulse", ns, 1);
        check("enc_nokey", nk, 0);
        check("enc_res", st_q, CT);
        check("enc_starts", starts - s0, 4);

        // state decrypt of previous result
        st_data = CT;
        st_dec  = 1'b1;
        st_req  = 1'b1;
        d0 = dec_cyc;
        run_jobs(45, 1'b0, kk, ks, nk, ns);
        check("dec_lat", ks, 33);
        check("dec_res", st_q, PT);
        check("dec_cyc", dec_cyc - d0, 32);
        check("dec_idle", sbx.sbx_decrypt_o, 0);

        // tie after a state job: key first in both modes
        key_data = 32'h1020_3040;
        st_data  = PT;
        st_dec   = 1'b0;
        key_req  = 1'b1;
        st_req   = 1'b1;
        run_jobs(55, 1'b0, kk, ks, nk, ns);
        check("tie1_key", kk, 9);
        check("tie1_st", ks, 43);
        check("tie1_kres", key_q, 32'hCAB7_0409);
        check("tie1_sres", st_q, CT);

        // key alone, then tie: mode decides
        key_data = 32'h0001_53FF;
        key_req  = 1'b1;
        run_jobs(12, 1'b0, kk, ks, nk, ns);
        check("pre_key", kk, 9);
        key_data = 32'h1020_3040;
        st_data  = CT;
        st_dec   = 1'b1;
        key_req  = 1'b1;
        st_req   = 1'b1;
        run_jobs(55, 1'b0, kk, ks, nk, ns);
`ifdef SBOX_RR_ARB_EN
        check("tie2_st", ks, 33);
        check("tie2_key", kk, 43);
`else
        check("tie2_key", kk, 9);
        check("tie2_st", ks, 43);
`endif
        check("tie2_sres", st_q, PT);
        check("tie2_kres", key_q, 32'hCAB7_0409);

        // engine never answers: timeout
        stub_off = 1'b1;
        key_data = 32'h0000_0000;
        key_req  = 1'b1;
        check("err_pre", err, 0);
        run_jobs(25, 1'b0, kk, ks, nk, ns);
        check("tmo_lat", kk, 17);
        check("tmo_err", err, 1);
        check("tmo_keep", key_q, 32'hCAB7_0409);
        stub_off = 1'b0;
        key_data = 32'h0001_53FF;
        key_req  = 1'b1;
        run_jobs(12, 1'b0, kk, ks, nk, ns);
        check("post_tmo_lat", kk, 9);
        check("post_tmo_res", key_q, 32'h637C_ED16);
        check("err_sticky", err, 1);

        // reset during word 2 of a state job
        st_data = PT;
        st_dec  = 1'b0;
        st_req  = 1'b1;
        run_jobs(20, 1'b0, kk, ks, nk, ns);
        check("mid_nodone", ns, 0);
        check("mid_busy", busy, 1);
        rst_n  = 1'b0;
        st_req = 1'b0;
        #1;
        check_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_jobs(10, 1'b0, kk, ks, nk, ns);
        check("rst_nopulse", nk + ns, 0);
        st_req = 1'b1;
        run_jobs(40, 1'b0, kk, ks, nk, ns);
        check("fresh_lat", ks, 33);
        check("fresh_res", st_q, CT);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
